pll_lock_sequencer: RTL and testbench

Reset and lock sequencer for the VGA pixel-clock PLL. It runs on the board reference clock and drives the PLL's active-high reset. It qualifies the PLL `locked` output over a stability window, then releases a reset for downstream pixel-domain logic. On lock timeout or lock loss it re-sequences the PLL, with bounded retries, and reports a sticky fault when the retries are exhausted.

---
 rtl/pll_lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the VGA pixel-clock PLL: holds the PLL in reset, qualifies lock, retries, faults.
// Define PLL_SEQ_LOSS_COUNT_EN to build the saturating lock-loss counter; otherwise lock_loss_count is 0.
module pll_lock_sequencer #(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       soft_reset,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       out_rst_n,
   output logic       ready,
   output logic       fault,
   output logic [3:0] retry_count,
   output logic [7:0] lock_loss_count
);
   localparam int PHASE_MAX = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
   localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam int TMO_W     = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam logic [PHASE_W-1:0] HOLD_LAST   = PHASE_W'(RST_HOLD_CYCLES - 1);
   localparam logic [PHASE_W-1:0] STABLE_LAST = PHASE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [3:0]         RETRY_MAX   = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {S_HOLD, S_WAIT, S_QUALIFY, S_RUN, S_FAULT} state_t;

   state_t             state_reg, state_next;
   logic [PHASE_W-1:0] phase_reg, phase_next;
   logic [TMO_W-1:0]   tmo_reg, tmo_next;
   logic [3:0]         retry_reg, retry_next;
   logic               sync1_reg, sync2_reg;
   logic               lock_s;
   logic               loss_event;
   logic               pll_rst_reg, out_rst_n_reg, ready_reg, fault_reg;

   assign lock_s = sync2_reg;

   always_comb begin
      state_next = state_reg;
      phase_next = phase_reg;
      tmo_next   = tmo_reg;
      retry_next = retry_reg;
      loss_event = 1'b0;
      if (soft_reset) begin
         state_next = S_HOLD;
         phase_next = '0;
         tmo_next   = '0;
         retry_next = '0;
      end else begin
         case (state_reg)
            S_HOLD: begin
               tmo_next = '0;
               if (phase_reg == HOLD_LAST) begin
                  state_next = S_WAIT;
                  phase_next = '0;
               end else begin
                  phase_next = phase_reg + 1'b1;
               end
            end
            S_WAIT, S_QUALIFY: begin
               tmo_next = tmo_reg + 1'b1;
               // Qualification completing on the timeout cycle still wins.
               if (state_reg == S_QUALIFY && lock_s && phase_reg == STABLE_LAST) begin
                  state_next = S_RUN;
                  phase_next = '0;
                  retry_next = '0;
               end else if (tmo_reg == TMO_LAST) begin
                  phase_next = '0;
                  tmo_next   = '0;
                  if (retry_reg < RETRY_MAX) begin
                     retry_next = retry_reg + 1'b1;
                     state_next = S_HOLD;
                  end else begin
                     state_next = S_FAULT;
                  end
               end else if (state_reg == S_WAIT) begin
                  if (lock_s) begin
                     state_next = S_QUALIFY;
                     phase_next = '0;
                  end
               end else if (lock_s) begin
                  phase_next = phase_reg + 1'b1;
               end else begin
                  state_next = S_WAIT;
                  phase_next = '0;
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_next = S_HOLD;
                  phase_next = '0;
                  tmo_next   = '0;
                  loss_event = 1'b1;
               end
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_HOLD;
         endcase
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg     <= 1'b0;
         sync2_reg     <= 1'b0;
         state_reg     <= S_HOLD;
         phase_reg     <= '0;
         tmo_reg       <= '0;
         retry_reg     <= '0;
         pll_rst_reg   <= 1'b1;
         out_rst_n_reg <= 1'b0;
         ready_reg     <= 1'b0;
         fault_reg     <= 1'b0;
      end else begin
         sync1_reg     <= pll_locked;
         sync2_reg     <= sync1_reg;
         state_reg     <= state_next;
         phase_reg     <= phase_next;
         tmo_reg       <= tmo_next;
         retry_reg     <= retry_next;
         pll_rst_reg   <= (state_next == S_HOLD) || (state_next == S_FAULT);
         out_rst_n_reg <= (state_next == S_RUN);
         ready_reg     <= (state_next == S_RUN);
         fault_reg     <= (state_next == S_FAULT);
      end
   end

   assign pll_rst     = pll_rst_reg;
   assign out_rst_n   = out_rst_n_reg;
   assign ready       = ready_reg;
   assign fault       = fault_reg;
   assign retry_count = retry_reg;

`ifdef PLL_SEQ_LOSS_COUNT_EN
   logic [7:0] loss_cnt_reg;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt_reg <= '0;
      end else if (loss_event && loss_cnt_reg != 8'hFF) begin
         loss_cnt_reg <= loss_cnt_reg + 8'd1;
      end
   end

   assign lock_loss_count = loss_cnt_reg;
`else
   logic unused_loss_event;
   assign unused_loss_event = loss_event;
   assign lock_loss_count   = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected event cycles/values are queued, then popped on observation.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;
   localparam int RST_HOLD = 4;
   localparam int STABLE   = 8;
   localparam int TMO      = 32;
   localparam int RETRIES  = 2;
`ifdef PLL_SEQ_LOSS_COUNT_EN
   localparam int LOSS_ONE = 1;
`else
   localparam int LOSS_ONE = 0;
`endif

   logic       refclk = 1'b0;
   logic       rst_n = 1'b1;
   logic       soft_reset = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_rst, out_rst_n, ready, fault;
   logic [3:0] retry_count;
   logic [7:0] lock_loss_count;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int base_cyc = 0;
   int rel;

   typedef struct {
      string tag;
      int    exp;
   } exp_t;
   exp_t sb_q[$];

   pll_lock_sequencer #(
      .RST_HOLD_CYCLES(RST_HOLD),
      .LOCK_STABLE_CYCLES(STABLE),
      .LOCK_TIMEOUT_CYCLES(TMO),
      .MAX_RETRIES(RETRIES)
   ) dut (
      .refclk(refclk),
      .rst_n(rst_n),
      .soft_reset(soft_reset),
      .pll_locked(pll_locked),
      .pll_rst(pll_rst),
      .out_rst_n(out_rst_n),
      .ready(ready),
      .fault(fault),
      .retry_count(retry_count),
      .lock_loss_count(lock_loss_count)
   );

   always #20 refclk = ~refclk;
   always @(posedge refclk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", tag, act);
      end
   endtask

   task automatic sb_push(input string tag, input int exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input int act);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_underflow", 0, 1);
      end else begin
         e = sb_q.pop_front();
         check_val(e.tag, act, e.exp);
      end
   endtask

   function automatic logic sig_sel(input int sel);
      case (sel)
         0: return pll_rst;
         1: return out_rst_n;
         2: return ready;
         default: return fault;
      endcase
   endfunction

   // Returns the cycle (relative to base_cyc) at which the selected output reaches val, or -1.
   task automatic wait_for(input int sel, input logic val, input int budget, output int cyc_rel);
      cyc_rel = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge refclk);
         if (sig_sel(sel) == val) begin
            cyc_rel = cyc - base_cyc;
            break;
         end
      end
   endtask

   task automatic do_soft_reset(input logic lock_val);
      @(negedge refclk);
      soft_reset = 1'b1;
      pll_locked = lock_val;
      base_cyc   = cyc;
      @(negedge refclk);
      soft_reset = 1'b0;
   endtask

   task automatic check_reset_values(input string pfx);
      sb_push({pfx, "_pll_rst"}, 1);       sb_check(int'(pll_rst));
      sb_push({pfx, "_out_rst_n"}, 0);     sb_check(int'(out_rst_n));
      sb_push({pfx, "_ready"}, 0);         sb_check(int'(ready));
      sb_push({pfx, "_fault"}, 0);         sb_check(int'(fault));
      sb_push({pfx, "_retry"}, 0);         sb_check(int'(retry_count));
      sb_push({pfx, "_loss_cnt"}, 0);      sb_check(int'(lock_loss_count));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge refclk);
      check_reset_values("rst");

      // 1: nominal lock
      rst_n = 1'b1;
      base_cyc = cyc;
      sb_push("t1_pll_rst_fall", 4);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      repeat (10) @(negedge refclk);
      pll_locked = 1'b1;
      sb_push("t1_out_rst_n_rise", 25);
      wait_for(1, 1'b1, 60, rel); sb_check(rel);
      sb_push("t1_ready", 1);              sb_check(int'(ready));
      sb_push("t1_retry", 0);              sb_check(int'(retry_count));

      // 2: one-cycle lock glitch during qualification
      do_soft_reset(1'b0);
      sb_push("t2_soft_pll_rst", 1);       sb_check(int'(pll_rst));
      sb_push("t2_soft_out_rst_n", 0);     sb_check(int'(out_rst_n));
      sb_push("t2_pll_rst_fall", 5);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      pll_locked = 1'b1;
      repeat (5) @(negedge refclk);
      pll_locked = 1'b0;
      @(negedge refclk);
      pll_locked = 1'b1;
      repeat (5) @(negedge refclk);
      sb_push("t2_not_ready_early", 0);    sb_check(int'(ready));
      sb_push("t2_ready_rise", 22);
      wait_for(2, 1'b1, 50, rel); sb_check(rel);
      sb_push("t2_retry", 0);              sb_check(int'(retry_count));

      // 3: no lock at all -> retries then fault
      do_soft_reset(1'b0);
      sb_push("t3_hold0_end", 5);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      sb_push("t3_hold1_start", 37);
      wait_for(0, 1'b1, 50, rel); sb_check(rel);
      sb_push("t3_retry1", 1);             sb_check(int'(retry_count));
      sb_push("t3_hold1_end", 41);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      sb_push("t3_hold2_start", 73);
      wait_for(0, 1'b1, 50, rel); sb_check(rel);
      sb_push("t3_retry2", 2);             sb_check(int'(retry_count));
      sb_push("t3_hold2_end", 77);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      sb_push("t3_fault_rise", 109);
      wait_for(3, 1'b1, 50, rel); sb_check(rel);
      sb_push("t3_fault_pll_rst", 1);      sb_check(int'(pll_rst));
      sb_push("t3_fault_out_rst_n", 0);    sb_check(int'(out_rst_n));
      repeat (60) @(negedge refclk);
      sb_push("t3_fault_sticky", 1);       sb_check(int'(fault));
      sb_push("t3_fault_pll_rst_held", 1); sb_check(int'(pll_rst));

      // 4: recovery from fault via soft_reset
      do_soft_reset(1'b0);
      sb_push("t4_fault_clr", 0);          sb_check(int'(fault));
      sb_push("t4_retry_clr", 0);          sb_check(int'(retry_count));
      sb_push("t4_pll_rst", 1);            sb_check(int'(pll_rst));
      sb_push("t4_pll_rst_fall", 5);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      pll_locked = 1'b1;
      sb_push("t4_ready_rise", 16);
      wait_for(2, 1'b1, 50, rel); sb_check(rel);
      sb_push("t4_out_rst_n", 1);          sb_check(int'(out_rst_n));

      // 5: lock loss while running
      @(negedge refclk);
      base_cyc = cyc;
      pll_locked = 1'b0;
      sb_push("t5_out_rst_n_fall", 3);
      wait_for(1, 1'b0, 20, rel); sb_check(rel);
      sb_push("t5_pll_rst", 1);            sb_check(int'(pll_rst));
      sb_push("t5_ready", 0);              sb_check(int'(ready));
      sb_push("t5_loss_cnt", LOSS_ONE);    sb_check(int'(lock_loss_count));
      sb_push("t5_pll_rst_fall", 7);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      pll_locked = 1'b1;
      sb_push("t5_ready_rise", 18);
      wait_for(2, 1'b1, 50, rel); sb_check(rel);

      // 6: asynchronous reset in the middle of qualification
      do_soft_reset(1'b0);
      sb_push("t6_pll_rst_fall", 5);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      pll_locked = 1'b1;
      repeat (6) @(negedge refclk);
      #2 rst_n = 1'b0;
      #2;
      check_reset_values("t6_async");
      pll_locked = 1'b0;
      repeat (3) @(negedge refclk);
      rst_n = 1'b1;
      base_cyc = cyc;
      sb_push("t6_restart_pll_rst_fall", 4);
      wait_for(0, 1'b0, 50, rel); sb_check(rel);
      sb_push("t6_fault", 0);              sb_check(int'(fault));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
